spi_master: RTL and testbench

SPI initiator that pairs with the existing SPI slave. It drives sclk, mosi and ss, and captures miso.
- Transfers one 8-bit word per request, full duplex.
- Mode 0: sclk idles low; mosi and miso are sampled on sclk rising edges; mosi changes on falling edges.
- Bit order is MSB first.
- Sits between a local requester (start/send_item) and the off-chip or on-chip SPI bus.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_clk_div.sv | 28 ++
 rtl/spi_master.sv | 96 +++++++++
 tb/tb_spi_master.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and master state encoding
package spi_pkg;

  localparam int SPI_WORD_BITS    = 8;
  localparam int SPI_HALF_PERIODS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - requester handshake and SPI bus signals of the SPI master
interface spi_master_if;
  import spi_pkg::*;

  logic                     start;
  logic [SPI_WORD_BITS-1:0] send_item;
  logic                     busy;
  logic                     done;
  logic [SPI_WORD_BITS-1:0] recv_item;
  logic                     sclk;
  logic                     mosi;
  logic                     ss;
  logic                     miso;

  modport master (
    input  start, send_item, miso,
    output busy, done, recv_item, sclk, mosi, ss
  );

  modport slave (
    output start, send_item, miso,
    input  busy, done, recv_item, sclk, mosi, ss
  );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - restartable divider producing one tick every CLK_DIV cycles
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Restart holds the count at zero so the first tick lands CLK_DIV cycles after state entry.
  assign tick = (cnt == LAST) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode 0, MSB-first, 8-bit full-duplex SPI master
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam logic [4:0] LAST_HALF = 5'(SPI_HALF_PERIODS - 1);

  spi_state_t               state;
  logic [SPI_WORD_BITS-2:0] tx_buf;
  logic [SPI_WORD_BITS-1:0] rx_buf;
  logic [4:0]               half_cnt;
  logic                     tick;
  logic                     restart;

  assign restart = (state == ST_IDLE) || (state == ST_DONE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      tx_buf        <= '0;
      rx_buf        <= '0;
      half_cnt      <= '0;
      bus.sclk      <= 1'b0;
      bus.mosi      <= 1'b0;
      bus.ss        <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.recv_item <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          half_cnt <= '0;
          if (bus.start) begin
            tx_buf   <= bus.send_item[SPI_WORD_BITS-2:0];
            bus.mosi <= bus.send_item[SPI_WORD_BITS-1];
            bus.ss   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= ST_SETUP;
          end else begin
            bus.ss   <= 1'b1;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            bus.sclk <= ~bus.sclk;
            if (!bus.sclk) begin
              rx_buf <= {rx_buf[SPI_WORD_BITS-2:0], bus.miso};
            end else begin
              // Zeros shift in behind the data, so the 8th falling edge drives mosi low.
              bus.mosi <= tx_buf[SPI_WORD_BITS-2];
              tx_buf   <= {tx_buf[SPI_WORD_BITS-3:0], 1'b0};
            end
            if (half_cnt == LAST_HALF) begin
              half_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              half_cnt <= half_cnt + 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            bus.ss        <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.recv_item <= rx_buf;
            state         <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  spi_master_if bus ();
  spi_master_if bus2 ();

  spi_master #(.CLK_DIV(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master #(.CLK_DIV(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // 0: loopback, 1: constant one, 2: simple mode 0 slave model
  int         miso_mode;
  logic [7:0] slv_tx;
  logic [7:0] slv_sh;
  logic [7:0] slv_rx;
  logic [2:0] slv_cnt;
  logic       slv_sclk_q;
  logic       slv_byte_received;

  always_comb begin
    case (miso_mode)
      0:       bus.miso = bus.mosi;
      1:       bus.miso = 1'b1;
      default: bus.miso = slv_sh[7];
    endcase
  end

  assign bus2.miso = bus2.mosi;

  always @(posedge clk) begin
    slv_sclk_q        <= bus.sclk;
    slv_byte_received <= 1'b0;
    if (bus.ss) begin
      slv_sh  <= slv_tx;
      slv_cnt <= 3'd0;
    end else if (bus.sclk && !slv_sclk_q) begin
      slv_rx  <= {slv_rx[6:0], bus.mosi};
      slv_cnt <= slv_cnt + 3'd1;
      if (slv_cnt == 3'd7) slv_byte_received <= 1'b1;
    end else if (!bus.sclk && slv_sclk_q) begin
      slv_sh <= {slv_sh[6:0], 1'b0};
    end
  end

  int         obs_done_cnt, obs_done_cyc, obs_rise_cnt;
  int         obs_ss_first, obs_ss_last, obs_ss_windows, obs_byte_rx;
  logic [7:0] obs_mosi_bits, obs_recv, obs_recv_init;
  logic       obs_recv_stable;

  task automatic run_xfer(input logic [7:0] data, input int ncyc, input int restart_cyc);
    logic prev_sclk, prev_ss;
    @(negedge clk);
    bus.send_item = data;
    bus.start     = 1'b1;
    @(posedge clk);
    prev_sclk = 1'b0; prev_ss = 1'b1;
    obs_done_cnt = 0; obs_done_cyc = 0; obs_rise_cnt = 0;
    obs_ss_first = 0; obs_ss_last = 0; obs_ss_windows = 0; obs_byte_rx = 0;
    obs_mosi_bits = 8'h00; obs_recv = 8'h00; obs_recv_stable = 1'b1;
    obs_recv_init = bus.recv_item;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.start = (c == restart_cyc);
      if (c == restart_cyc) bus.send_item = 8'hFF;
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) obs_done_cyc = c;
        obs_recv = bus.recv_item;
      end else if (obs_done_cnt == 0 && bus.recv_item !== obs_recv_init) begin
        obs_recv_stable = 1'b0;
      end
      if (bus.sclk && !prev_sclk) begin
        obs_rise_cnt++;
        obs_mosi_bits = {obs_mosi_bits[6:0], bus.mosi};
      end
      if (!bus.ss) begin
        if (prev_ss) obs_ss_windows++;
        if (obs_ss_first == 0) obs_ss_first = c;
        obs_ss_last = c;
      end
      if (slv_byte_received) obs_byte_rx++;
      prev_sclk = bus.sclk;
      prev_ss   = bus.ss;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.ss !== 1'b1) begin n_fail++; $display("FAIL reset_ss: got %b want 1", bus.ss); end
    n_tests++; if (bus.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", bus.sclk); end
    n_tests++; if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", bus.mosi); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.recv_item !== 8'h00) begin n_fail++; $display("FAIL reset_recv: got %h want 00", bus.recv_item); end
    n_tests++; if (bus2.ss !== 1'b1) begin n_fail++; $display("FAIL reset_ss2: got %b want 1", bus2.ss); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.ss !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got ss=%b busy=%b want ss=1 busy=0", bus.ss, bus.busy); end
  endtask

  task automatic test_loopback();
    miso_mode = 0;
    run_xfer(8'hA5, 45, 0);
    n_tests++; if (obs_done_cyc !== 37) begin n_fail++; $display("FAIL lb_done_cycle: got %0d want 37", obs_done_cyc); end
    n_tests++; if (obs_done_cnt !== 1) begin n_fail++; $display("FAIL lb_done_count: got %0d want 1", obs_done_cnt); end
    n_tests++; if (obs_recv !== 8'hA5) begin n_fail++; $display("FAIL lb_recv: got %h want a5", obs_recv); end
    n_tests++; if (obs_rise_cnt !== 8) begin n_fail++; $display("FAIL lb_rises: got %0d want 8", obs_rise_cnt); end
    n_tests++; if (obs_ss_first !== 1 || obs_ss_last !== 36) begin n_fail++; $display("FAIL lb_ss_window: got %0d-%0d want 1-36", obs_ss_first, obs_ss_last); end
    n_tests++; if (obs_mosi_bits !== 8'hA5) begin n_fail++; $display("FAIL lb_mosi_bits: got %h want a5", obs_mosi_bits); end
    n_tests++; if (bus.mosi !== 1'b0 || bus.sclk !== 1'b0) begin n_fail++; $display("FAIL lb_idle_lines: got mosi=%b sclk=%b want 0 0", bus.mosi, bus.sclk); end
  endtask

  task automatic test_miso_one();
    miso_mode = 1;
    run_xfer(8'h3C, 45, 0);
    n_tests++; if (obs_recv !== 8'hFF) begin n_fail++; $display("FAIL one_recv: got %h want ff", obs_recv); end
    n_tests++; if (obs_mosi_bits !== 8'h3C) begin n_fail++; $display("FAIL one_mosi_bits: got %h want 3c", obs_mosi_bits); end
    n_tests++; if (!obs_recv_stable) begin n_fail++; $display("FAIL one_recv_hold: got changed want held at %h", obs_recv_init); end
    n_tests++; if (obs_done_cyc !== 37) begin n_fail++; $display("FAIL one_done_cycle: got %0d want 37", obs_done_cyc); end
  endtask

  task automatic test_start_ignored();
    miso_mode = 0;
    run_xfer(8'hC3, 45, 10);
    n_tests++; if (obs_done_cnt !== 1 || obs_done_cyc !== 37) begin n_fail++; $display("FAIL ign_done: got count=%0d cycle=%0d want 1 at 37", obs_done_cnt, obs_done_cyc); end
    n_tests++; if (obs_ss_windows !== 1) begin n_fail++; $display("FAIL ign_ss_windows: got %0d want 1", obs_ss_windows); end
    n_tests++; if (obs_recv !== 8'hC3) begin n_fail++; $display("FAIL ign_recv: got %h want c3", obs_recv); end
  endtask

  task automatic test_reset_abort();
    int bad;
    miso_mode = 0;
    @(negedge clk);
    bus.send_item = 8'h66;
    bus.start     = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.ss !== 1'b1 || bus.sclk !== 1'b0) begin n_fail++; $display("FAIL abort_lines: got ss=%b sclk=%b want 1 0", bus.ss, bus.sclk); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.recv_item !== 8'h00) begin n_fail++; $display("FAIL abort_recv: got %h want 00", bus.recv_item); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done || bus.sclk || !bus.ss || bus.busy) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    run_xfer(8'h96, 45, 0);
    n_tests++; if (obs_done_cyc !== 37 || obs_recv !== 8'h96) begin n_fail++; $display("FAIL abort_restart: got cycle=%0d recv=%h want 37 96", obs_done_cyc, obs_recv); end
  endtask

  task automatic test_back_to_back();
    int         d1, d2, dcnt;
    logic [7:0] r1, r2;
    logic       ss18, ss19, ss20;
    d1 = 0; d2 = 0; dcnt = 0; r1 = 8'h00; r2 = 8'h00;
    ss18 = 1'b1; ss19 = 1'b0; ss20 = 1'b1;
    @(negedge clk);
    bus2.send_item = 8'h01;
    bus2.start     = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) bus2.send_item = 8'h80;
      if (c == 20) bus2.start = 1'b0;
      if (bus2.done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = c; r1 = bus2.recv_item; end
        if (dcnt == 2) begin d2 = c; r2 = bus2.recv_item; end
      end
      if (c == 18) ss18 = bus2.ss;
      if (c == 19) ss19 = bus2.ss;
      if (c == 20) ss20 = bus2.ss;
    end
    n_tests++; if (d1 !== 19 || r1 !== 8'h01) begin n_fail++; $display("FAIL b2b_first: got cycle=%0d recv=%h want 19 01", d1, r1); end
    n_tests++; if (d2 !== 38 || r2 !== 8'h80) begin n_fail++; $display("FAIL b2b_second: got cycle=%0d recv=%h want 38 80", d2, r2); end
    n_tests++; if (dcnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
    n_tests++; if ({ss18, ss19, ss20} !== 3'b010) begin n_fail++; $display("FAIL b2b_ss_gap: got %b want 010", {ss18, ss19, ss20}); end
  endtask

  task automatic test_slave();
    slv_tx    = 8'h81;
    miso_mode = 2;
    repeat (2) @(negedge clk);
    run_xfer(8'h5A, 45, 0);
    n_tests++; if (slv_rx !== 8'h5A) begin n_fail++; $display("FAIL slv_rx: got %h want 5a", slv_rx); end
    n_tests++; if (obs_byte_rx !== 1) begin n_fail++; $display("FAIL slv_byte_received: got %0d want 1", obs_byte_rx); end
    n_tests++; if (obs_done_cnt !== 1) begin n_fail++; $display("FAIL slv_done: got %0d want 1", obs_done_cnt); end
    n_tests++; if (obs_recv !== 8'h81) begin n_fail++; $display("FAIL slv_master_recv: got %h want 81", obs_recv); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_tests = 0;
    n_fail = 0;
    miso_mode = 0;
    slv_tx = 8'h00;
    bus.start = 1'b0;
    bus.send_item = 8'h00;
    bus2.start = 1'b0;
    bus2.send_item = 8'h00;
    test_reset();
    test_loopback();
    test_miso_one();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_slave();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
